// File: rtl/ram_8bits_controller_if.sv
// Request/response, fill and RAM-pin bundle for the RAM_8bits controller.
// The slave modport is the controller's view; master is the requester/RAM side.
interface ram_8bits_controller_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  fill_start;
  logic [DATA_WIDTH-1:0] fill_value;
  logic                  fill_busy;
  logic                  fill_done;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic [DATA_WIDTH-1:0] ram_data_out;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_data,
    input  rsp_ready,
    input  fill_start, fill_value,
    output fill_busy, fill_done,
    output ram_address, ram_we, ram_data_in,
    input  ram_data_out
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_data,
    output rsp_ready,
    output fill_start, fill_value,
    input  fill_busy, fill_done,
    input  ram_address, ram_we, ram_data_in,
    output ram_data_out
  );
endinterface

// File: rtl/ram_8bits_controller.sv
// Sequencer for the synchronous RAM_8bits array: single read/write requests,
// held read responses, and a fill engine that writes one value to every word.
// The registered RAM pins double as the request latches: the address register
// holds the read address for the whole read, and during a fill it is the
// fill address counter.
module ram_8bits_controller #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int FILL_LAST    = 31
) (
  input logic clock,
  input logic reset,
  ram_8bits_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RESP,
    FILL
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] FILL_END = ADDR_WIDTH'(FILL_LAST);
  localparam logic [2:0]            LAT_END  = 3'(READ_LATENCY);

  state_t                state, state_n;
  logic [2:0]            lat_cnt, lat_cnt_n;
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_n;
  logic                  ram_we_q, ram_we_n;
  logic [DATA_WIDTH-1:0] ram_data_in_q, ram_data_in_n;
  logic                  rsp_valid_q, rsp_valid_n;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_n;
  logic                  fill_busy_q, fill_busy_n;
  logic                  fill_done_q, fill_done_n;
  logic                  accept;

  // Requests are only taken in IDLE, and a simultaneous fill_start steals the slot.
  assign bus.req_ready = (state == IDLE) & ~bus.fill_start & ~reset;
  assign accept        = bus.req_valid & bus.req_ready;

  assign bus.ram_address = ram_address_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_data_in = ram_data_in_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.fill_busy   = fill_busy_q;
  assign bus.fill_done   = fill_done_q;

  // State and every registered output; reset drops any in-flight request or fill.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      ram_address_q <= '0;
      ram_we_q      <= 1'b0;
      ram_data_in_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      fill_busy_q   <= 1'b0;
      fill_done_q   <= 1'b0;
    end else begin
      state         <= state_n;
      lat_cnt       <= lat_cnt_n;
      ram_address_q <= ram_address_n;
      ram_we_q      <= ram_we_n;
      ram_data_in_q <= ram_data_in_n;
      rsp_valid_q   <= rsp_valid_n;
      rsp_data_q    <= rsp_data_n;
      fill_busy_q   <= fill_busy_n;
      fill_done_q   <= fill_done_n;
    end
  end

  // Next state and next values of the registered outputs; WE defaults low and
  // fill_done defaults low so both are only asserted where explicitly wanted.
  always_comb begin
    state_n       = state;
    lat_cnt_n     = lat_cnt;
    ram_address_n = ram_address_q;
    ram_we_n      = 1'b0;
    ram_data_in_n = ram_data_in_q;
    rsp_valid_n   = rsp_valid_q;
    rsp_data_n    = rsp_data_q;
    fill_busy_n   = fill_busy_q;
    fill_done_n   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.fill_start) begin
          state_n       = FILL;
          ram_we_n      = 1'b1;
          ram_address_n = '0;
          ram_data_in_n = bus.fill_value;
          fill_busy_n   = 1'b1;
        end else if (accept) begin
          ram_address_n = bus.req_addr;
          if (bus.req_write) begin
            state_n       = WRITE;
            ram_we_n      = 1'b1;
            ram_data_in_n = bus.req_wdata;
          end else begin
            state_n   = READ;
            lat_cnt_n = '0;
          end
        end
      end

      WRITE: begin
        state_n = IDLE;
      end

      READ: begin
        // The RAM samples the address one edge after accept, then needs
        // READ_LATENCY more edges before dataOut is worth capturing.
        if (lat_cnt == LAT_END) begin
          rsp_data_n  = bus.ram_data_out;
          rsp_valid_n = 1'b1;
          state_n     = RESP;
        end else begin
          lat_cnt_n = lat_cnt + 3'd1;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end

      FILL: begin
        if (ram_address_q == FILL_END) begin
          fill_busy_n = 1'b0;
          fill_done_n = 1'b1;
          state_n     = IDLE;
        end else begin
          ram_we_n      = 1'b1;
          ram_address_n = ram_address_q + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_8bits_controller.sv
// Directed bench for ram_8bits_controller with a behavioural RAM_8bits model
// (read-first, one-edge read latency) hanging off the RAM pins.
module tb_ram_8bits_controller;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  ram_8bits_controller_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  ram_8bits_controller #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .READ_LATENCY(1),
    .FILL_LAST(31)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  // Free-running 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model: writes on WE, dataOut registered from the sampled address
  logic [7:0] mem [0:255];
  always @(posedge clock) begin
    if (bus.ram_we) mem[bus.ram_address] <= bus.ram_data_in;
    bus.ram_data_out <= mem[bus.ram_address];
  end

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Waits (bounded) for req_ready, presents one request, returns at the
  // negedge just after the accept edge with req_valid dropped.
  task automatic applyStimulus(input logic write, input logic [7:0] addr, input logic [7:0] data);
    int waited = 0;
    while (!bus.req_ready && waited < 100) begin
      tick();
      waited++;
    end
    checkOutput("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_write = write;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    bus.req_addr  = 8'hEE;
    bus.req_wdata = 8'hEE;
  endtask

  task automatic doWrite(input logic [7:0] addr, input logic [7:0] data);
    applyStimulus(1'b1, addr, data);
    checkOutput("write_pins", {15'd0, bus.ram_we, bus.ram_address, bus.ram_data_in}, {15'd0, 1'b1, addr, data});
    tick();
    checkOutput("write_done", {30'd0, bus.ram_we, bus.req_ready}, 32'd1);
  endtask

  // Read with rsp_ready held high: response must appear exactly two edges after accept
  task automatic doRead(input string tag, input logic [7:0] addr, input logic [7:0] expected);
    bus.rsp_ready = 1'b1;
    applyStimulus(1'b0, addr, 8'h00);
    checkOutput({tag, "_addr"}, {23'd0, bus.ram_we, bus.ram_address}, {23'd0, 1'b0, addr});
    checkOutput({tag, "_e0"}, {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    checkOutput({tag, "_e1"}, {31'd0, bus.rsp_valid}, 32'd0);
    tick();
    checkOutput({tag, "_data"}, {23'd0, bus.rsp_valid, bus.rsp_data}, {23'd0, 1'b1, expected});
    tick();
    checkOutput({tag, "_idle"}, {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
  endtask

  task automatic startFill(input logic [7:0] value);
    bus.fill_start = 1'b1;
    bus.fill_value = value;
    @(posedge clock);
    @(negedge clock);
    bus.fill_start = 1'b0;
    bus.fill_value = 8'h00;
  endtask

  initial begin
    int waited;
    logic saw_done;
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    bus.rsp_ready = 1'b1;
    bus.fill_start = 1'b0;
    bus.fill_value = 8'h00;

    // Reset state, checked before any clock edge
    #1;
    checkOutput("reset_pins", {15'd0, bus.ram_we, bus.ram_address, bus.ram_data_in}, 32'd0);
    checkOutput("reset_rsp", {22'd0, bus.rsp_valid, bus.req_ready, bus.rsp_data}, 32'd0);
    checkOutput("reset_fill", {30'd0, bus.fill_busy, bus.fill_done}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("post_reset_ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clock);

    // 1: write 10 @0, read back
    doWrite(8'h00, 8'd10);
    doRead("t1_rd0", 8'h00, 8'd10);

    // 2: write 15 @8, read @8 and @0
    doWrite(8'h08, 8'd15);
    doRead("t2_rd8", 8'h08, 8'd15);
    doRead("t2_rd0", 8'h00, 8'd10);

    // 3: response held while rsp_ready is low
    bus.rsp_ready = 1'b0;
    applyStimulus(1'b0, 8'h08, 8'h00);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_hold", {22'd0, bus.rsp_valid, bus.req_ready, bus.rsp_data}, {22'd0, 1'b1, 1'b0, 8'd15});
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    checkOutput("t3_release", {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);

    // 4: fill with 0xA5, one write per cycle over 0..31
    startFill(8'hA5);
    for (int i = 0; i < 32; i++) begin
      checkOutput("t4_fill_cycle", {13'd0, bus.ram_we, bus.fill_busy, bus.fill_done, bus.ram_address, bus.ram_data_in},
                  {13'd0, 1'b1, 1'b1, 1'b0, 8'(i), 8'hA5});
      tick();
    end
    checkOutput("t4_fill_end", {29'd0, bus.ram_we, bus.fill_busy, bus.fill_done}, 32'd1);
    tick();
    checkOutput("t4_done_pulse", {29'd0, bus.ram_we, bus.fill_busy, bus.fill_done}, 32'd0);
    doRead("t4_rd0", 8'h00, 8'hA5);
    doRead("t4_rd31", 8'd31, 8'hA5);

    // 5: fill_start and a write in the same cycle; fill wins, write follows fill_done
    bus.fill_start = 1'b1;
    bus.fill_value = 8'h00;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_addr   = 8'h04;
    bus.req_wdata  = 8'h33;
    #1;
    checkOutput("t5_ready_blocked", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    bus.fill_start = 1'b0;
    checkOutput("t5_fill_won", {14'd0, bus.ram_we, bus.fill_busy, bus.ram_address, bus.ram_data_in},
                {14'd0, 1'b1, 1'b1, 8'h00, 8'h00});
    waited = 0;
    while (!bus.req_ready && waited < 100) begin
      tick();
      waited++;
    end
    saw_done = bus.fill_done;
    checkOutput("t5_accept_after_done", {30'd0, bus.req_ready, saw_done}, 32'd3);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    checkOutput("t5_write_pins", {15'd0, bus.ram_we, bus.ram_address, bus.ram_data_in}, {15'd0, 1'b1, 8'h04, 8'h33});
    tick();
    doRead("t5_rd4", 8'h04, 8'h33);
    doRead("t5_rd5", 8'h05, 8'h00);

    // 6: reset mid-fill at address 12 clears outputs without a clock edge
    startFill(8'hC3);
    for (int i = 0; i < 12; i++) tick();
    checkOutput("t6_at12", {15'd0, bus.ram_we, bus.ram_address, bus.ram_data_in}, {15'd0, 1'b1, 8'd12, 8'hC3});
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t6_async_clear", {21'd0, bus.ram_we, bus.fill_busy, bus.rsp_valid, bus.ram_address}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    doRead("t6_rd0", 8'h00, 8'hC3);
    doRead("t6_rd11", 8'd11, 8'hC3);
    doRead("t6_rd12", 8'd12, 8'h00);
    doRead("t6_rd31", 8'd31, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
